rf16x8_wr_port: RTL
===================

# rf16x8_wr_port

Write-side stage of the 16-entry × 8-bit input-queue register file; it owns the storage array that the downstream read-port stage samples. It registers incoming writes, commits them one cycle later against a sticky per-entry write-lock mask, and clears the array by hardware sequencing after reset or on request. The combinational `rd_data` output feeds the downstream read-port stage, which registers it on its own read clock.

## Interface
- `DEPTH`, 16: number of entries; must be a power of two.
- `WIDTH`, 8: entry width; the downstream stage consumes it as four 2-bit lanes.
- `ADDR_W`, 4: address width, equal to log2(`DEPTH`).

- `wr_clk` input 1: the only clock; everything is on the posedge.
- `reset_l` input 1: asynchronous, active-low reset.
- `wen` input 1: write request; sampled only when `wr_rdy`=1.
- `wr_addr` input `ADDR_W`: write address.
- `wr_data` input `WIDTH`: write data.
- `lk_wen` input 1: lock update strobe.
- `lk_mask` input `DEPTH`: bits OR-ed into the lock register.
- `clr_req` input 1: request a clear of all unlocked entries.
- `rd_addr` input `ADDR_W`: read address from the downstream stage.
- `rd_data` output `WIDTH`: combinational array read at `rd_addr`.
- `wr_rdy` output 1: high when the block accepts `wen` and `clr_req`.
- `wr_err` output 1: one-cycle pulse when a write to a locked entry is dropped.
- `lock_q` output `DEPTH`: current lock register.

## Operation
- **FSM states:**
  - INIT: reset state.
  - RUN: normal operation.
  - CLR: clear in progress.
- **INIT:**
  - Clears entry `cnt` each cycle, for `cnt` = 0..15, ignoring locks.
  - Moves to RUN on the edge that clears entry 15.
- **CLR:**
  - Entered from RUN when `clr_req`=1 with `wr_rdy`=1.
  - Clears entry `cnt` each cycle unless `lock_q[cnt]`=1, for `cnt` = 0..15.
  - Returns to RUN on the edge that processes entry 15.
- **Counter:** `cnt` is 4 bits and wraps 15→0 on the exit edge.
- **`wr_rdy`:** 1 only in RUN.
- **`rd_data`:** forced to 0 in INIT; in RUN and CLR it reflects the array.
- **Write pipeline:**
  - Stage 1 captures `wen`, `wr_addr` and `wr_data` when `wr_rdy`=1.
  - Stage 2 commits: it writes the array if `lock_q[addr]`=0, otherwise it drops the write and pulses `wr_err`.
- **Lock register:**
  - Update rule: `lock_q <= lock_q | lk_mask` when `lk_wen`=1, in any state.
  - Bits clear only on reset; a 1 can never be cleared by `lk_mask`.
- **Lock check timing:** the commit check uses the `lock_q` value present during the commit cycle. A lock set on the same edge as the stage-1 capture therefore blocks that write.
- **`clr_req` and `wen` together:**
  - `clr_req` wins and the `wen` is discarded, with no `wr_err`.
  - A write already held in stage 1 still commits on the edge entering CLR.
- **`clr_req` while `wr_rdy`=0:** ignored, not queued.
- **Addresses:** no out-of-range case; `ADDR_W` covers `DEPTH` exactly.

## Timing
- **Reset values (asynchronous, `reset_l`=0):**
  - state = INIT, `cnt` = 0.
  - stage-1 valid = 0.
  - `lock_q` = 0, `wr_err` = 0, `wr_rdy` = 0, `rd_data` = 0.
  - The array is not asynchronously reset; INIT clears it.
- **First write:** `wr_rdy` rises on the 16th posedge after reset deassertion; the first `wen` is sampled on the 17th.
- **Write latency:**
  - `wen` sampled at edge E; array updated at E+1.
  - `rd_data` shows the new value after E+1, i.e. in the cycle following E+1.
- **`wr_err`:** high for exactly the cycle after the dropping commit edge.
- **Throughput:** back-to-back writes, one per cycle, in RUN.
  - Two writes to the same address: the later one wins.
  - A read of an address with a pending commit sees the old data, unless bypass is enabled (see Configuration).
- **CLR duration:** 16 cycles with `wr_rdy`=0; RUN resumes after the 16th edge.
- **Reset mid-INIT or mid-CLR:** immediate return to INIT with `cnt`=0. Any pending stage-1 write is discarded.

## Configuration
- **Macro:** `RF16X8_WR_BYPASS_EN`.
- **Defined:** `rd_data` returns stage-1 `wr_data` when all of the following hold:
  - stage 1 is valid;
  - stage-1 address equals `rd_addr`;
  - `lock_q[addr]`=0;
  - state is not INIT.
  
  This gives zero-cycle read-after-write visibility.
- **Undefined:** `rd_data` is always a pure array read, and the bypass logic is absent.

## Test plan
- **Reset and init:** release `reset_l`, then hold `rd_addr`=5 → `rd_data`=0 and `wr_rdy`=0 for 16 cycles, then `wr_rdy`=1; all entries read 0x00.
- **Basic write:** `wen`=1, `wr_addr`=3, `wr_data`=0xA5 at edge E → `rd_data`@3 = 0xA5 after E+1. Without bypass it is old data between E and E+1; with `RF16X8_WR_BYPASS_EN` it is 0xA5 immediately after E.
- **Lock:** `lk_wen`=1 with `lk_mask`=0x0008, then write 0x3C to address 3 → entry unchanged, `wr_err`=1 for exactly one cycle; then `lk_mask`=0 → `lock_q` stays 0x0008.
- **Same-edge lock:** `lk_wen` (mask bit 7) and a write to address 7 at the same edge → write dropped, `wr_err` pulses.
- **Clear:**
  - Fill all entries with 0xFF and lock entry 9, then pulse `clr_req` together with `wen` (addr 2, data 0x11).
  - Required: the write is discarded and `wr_rdy`=0 for 16 cycles; afterwards entry 9 = 0xFF and all others = 0x00.
- **Reset mid-CLR:** assert `reset_l`=0 at CLR cycle 6 → `lock_q`=0 and `wr_rdy`=0 at once. After release, a full 16-cycle INIT runs and all entries read 0.

Source files
------------

// File: rtl/rf16x8_wr_port.sv
// Write-side stage of the 16x8 input-queue register file: write pipeline, sticky lock mask, hardware clear.
// Optional macro RF16X8_WR_BYPASS_EN forwards the pending stage-1 write onto rd_data.
module rf16x8_wr_port #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              wr_clk,
    input  logic              reset_l,
    input  logic              wen,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              lk_wen,
    input  logic [DEPTH-1:0]  lk_mask,
    input  logic              clr_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              wr_rdy,
    output logic              wr_err,
    output logic [DEPTH-1:0]  lock_q,
    output logic [1:0]        dbg_state
);

    // Handshake: wen and clr_req are accepted only on a posedge where wr_rdy=1;
    // when both are high clr_req wins and the write is silently discarded.

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_CLR  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic                s1_vld;
    logic [ADDR_W-1:0]   s1_addr;
    logic [WIDTH-1:0]    s1_data;
    logic [WIDTH-1:0]    mem [DEPTH];
    logic                commit_ok;

    assign wr_rdy    = (state == ST_RUN);
    assign dbg_state = state;
    assign commit_ok = s1_vld && !lock_q[s1_addr];

    always_ff @(posedge wr_clk or negedge reset_l) begin
        if (!reset_l) begin
            state   <= ST_INIT;
            cnt     <= '0;
            s1_vld  <= 1'b0;
            s1_addr <= '0;
            s1_data <= '0;
            lock_q  <= '0;
            wr_err  <= 1'b0;
        end else begin
            if (lk_wen)
                lock_q <= lock_q | lk_mask;
            // Lock check sees lock_q of the commit cycle, so a same-edge lock blocks the write.
            wr_err <= s1_vld && lock_q[s1_addr];
            s1_vld <= wr_rdy && wen && !clr_req;
            if (wr_rdy && wen) begin
                s1_addr <= wr_addr;
                s1_data <= wr_data;
            end
            case (state)
                ST_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    if (clr_req)
                        state <= ST_CLR;
                end
                ST_CLR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST)
                        state <= ST_RUN;
                end
                default: begin
                    state <= ST_INIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Storage has no reset; INIT sweeps it to zero. Commits never coincide with a sweep.
    always_ff @(posedge wr_clk) begin
        if (state == ST_INIT)
            mem[cnt] <= '0;
        else if (state == ST_CLR && !lock_q[cnt])
            mem[cnt] <= '0;
        else if (commit_ok)
            mem[s1_addr] <= s1_data;
    end

    always_comb begin
        rd_data = mem[rd_addr];
`ifdef RF16X8_WR_BYPASS_EN
        if (s1_vld && s1_addr == rd_addr && !lock_q[s1_addr])
            rd_data = s1_data;
`endif
        if (state == ST_INIT)
            rd_data = '0;
    end

endmodule
